icnd2110_pixel_src: RTL and testbench

- Upstream pixel source for the ICND2110 daisy-chain SPI driver.
- On each frame-start pulse, streams exactly chipcount x CHANNELS 16-bit channel words over a valid/ready handshake, in chain order: chip 0 channel 0 first.
- Generates test patterns (solid, ramp, chase, off) that advance once per frame, so the LED string animates without a host.

---
 rtl/icnd2110_pkg.sv | 14 +
 rtl/icnd2110_pattern_lut.sv | 32 +++
 rtl/icnd2110_pixel_src.sv | 110 +++++++++++
 tb/tb_icnd2110_pixel_src.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icnd2110_pkg.sv
// icnd2110_pkg: shared definitions for the ICND2110 pixel source.
//   MODE_*       pattern select encodings carried on the 2-bit mode input
//   *_DEF        default channel count and word widths
//   state_t      frame streaming state encoding
package icnd2110_pkg;
    localparam int CHANNELS_DEF = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int CNT_W_DEF    = 16;
    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;
    typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/icnd2110_pattern_lut.sv
// icnd2110_pattern_lut: combinational test-pattern word generator.
//   mode        pattern select (solid, ramp, chase, off)
//   brightness  level used by solid and chase
//   chip        low byte of the chip index (only the low byte feeds the ramp)
//   ch          channel index within the chip
//   f           low byte of the frame count latched at frame accept
//   word        resulting channel word
module icnd2110_pattern_lut
    import icnd2110_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    localparam int CH_W    = $clog2(CHANNELS)
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] brightness,
    input  logic [7:0]        chip,
    input  logic [CH_W-1:0]   ch,
    input  logic [7:0]        f,
    output logic [DATA_W-1:0] word
);
    // CHANNELS is a power of two, so chip*CHANNELS + ch is a shift and OR
    logic [7:0]  ramp;
    logic [15:0] ramp_word;
    assign ramp      = (chip << CH_W) + 8'(ch) + f;
    assign ramp_word = {ramp, 8'h00};
    always_comb begin
        word = mode == MODE_SOLID ? brightness :
               mode == MODE_RAMP  ? DATA_W'(ramp_word) :
               (mode == MODE_CHASE && ch == f[CH_W-1:0]) ? brightness : '0;
    end
endmodule

// File: rtl/icnd2110_pixel_src.sv
// icnd2110_pixel_src: per-frame pattern word source for the ICND2110 chain driver.
//   clk, rst              system clock; asynchronous active-low reset
//   frame_start           request one frame (chipcount x CHANNELS words)
//   chipcount/mode/brightness  frame parameters, sampled at frame accept
//   data/data_valid/data_ready/data_last  output word stream, last flags final word
//   busy                  frame in progress
//   drop                  one-cycle pulse for an ignored frame_start
//   frame_cnt             completed frame count
module icnd2110_pixel_src
    import icnd2110_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  chipcount,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] brightness,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              data_last,
    output logic              busy,
    output logic              drop,
    output logic [15:0]       frame_cnt
);
    localparam int CH_W = $clog2(CHANNELS);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cc_q, cc_l, chip, nxt_chip;
    logic [CH_W-1:0]   ch, nxt_ch;
    logic [1:0]        mode_q, mode_l;
    logic [DATA_W-1:0] bright_q, bright_l, word;
    logic [7:0]        f_q, f_l;
    logic              accept, xfer, step, done, last_n;

    assign accept = state == IDLE && frame_start && chipcount != '0;
    assign xfer   = data_valid && data_ready;
    assign step   = xfer && !data_last;
    assign done   = xfer && data_last;
    assign busy   = state == STREAM;

    // Indices of the word about to be loaded: word 0 on accept, else the successor
    assign nxt_ch   = accept ? '0 : ch + CH_W'(1);
    assign nxt_chip = accept ? '0 : &ch ? chip + CNT_W'(1) : chip;
    // On accept the frame parameters come straight from the inputs
    assign cc_l     = accept ? chipcount : cc_q;
    assign mode_l   = accept ? mode : mode_q;
    assign bright_l = accept ? brightness : bright_q;
    assign f_l      = accept ? frame_cnt[7:0] : f_q;
    assign last_n   = nxt_chip == cc_l - CNT_W'(1) && &nxt_ch;

    icnd2110_pattern_lut #(.CHANNELS(CHANNELS), .DATA_W(DATA_W)) u_lut (
        .mode       (mode_l),
        .brightness (bright_l),
        .chip       (nxt_chip[7:0]),
        .ch         (nxt_ch),
        .f          (f_l),
        .word       (word)
    );

    always_comb begin
        state_d = accept ? STREAM : done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cc_q       <= '0;
            mode_q     <= '0;
            bright_q   <= '0;
            f_q        <= '0;
            chip       <= '0;
            ch         <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            drop       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            drop <= frame_start && !accept;
            if (accept) begin
                cc_q     <= chipcount;
                mode_q   <= mode;
                bright_q <= brightness;
                f_q      <= frame_cnt[7:0];
            end
            // accept only happens with the output empty, step only on a transfer
            if (accept || step) begin
                ch         <= nxt_ch;
                chip       <= nxt_chip;
                data       <= word;
                data_last  <= last_n;
                data_valid <= 1'b1;
            end else if (done) begin
                data       <= '0;
                data_last  <= 1'b0;
                data_valid <= 1'b0;
                frame_cnt  <= frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_icnd2110_pixel_src.sv
// tb_icnd2110_pixel_src: self-checking bench with a frame-level word-queue model.
module tb_icnd2110_pixel_src;
    localparam int CH = 16;

    logic        clk = 0, rst = 1, frame_start = 0, data_ready = 1;
    logic [15:0] chipcount = 0, brightness = 0;
    logic [1:0]  mode = 0;
    logic [15:0] data, frame_cnt;
    logic        data_valid, data_last, busy, drop;

    int n_cmp = 0, n_bad = 0;
    bit bp = 0;

    logic [15:0] exp_q[$];
    logic [15:0] seen[$];
    bit          m_active = 0, m_drop = 0, held = 0, was;
    logic [15:0] m_fc = 0, h_data, e;
    logic        h_last;
    int          n_last = 0, last_idx = -1, n_drop = 0;
    int          d0, nf;
    logic [15:0] f0;

    icnd2110_pixel_src dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .chipcount   (chipcount),
        .mode        (mode),
        .brightness  (brightness),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_last   (data_last),
        .busy        (busy),
        .drop        (drop),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pix(input logic [1:0] m, input logic [15:0] b,
                                        input int chip, input int ch, input logic [15:0] f);
        int w;
        w = chip * CH + ch;
        case (m)
            2'd0:    return b;
            2'd1:    return 16'(((w + int'(f)) % 256) * 256);
            2'd2:    return (ch == int'(f) % CH) ? b : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // Model: a frame accept enqueues every word of the frame; each transfer pops one.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_active = 0;
            m_drop   = 0;
            m_fc     = 0;
            held     = 0;
        end else begin
            was = m_active;
            chk("valid", data_valid, was);
            chk("busy", busy, was);
            chk("frame_cnt", frame_cnt, m_fc);
            chk("drop", drop, m_drop);
            if (drop) n_drop++;
            if (held) begin
                chk("hold_data", data, h_data);
                chk("hold_last", data_last, h_last);
            end
            held = 0;
            if (was && data_ready) begin
                e = exp_q.pop_front();
                chk("data", data, e);
                chk("last", data_last, exp_q.size() == 0);
                seen.push_back(data);
                if (data_last) begin
                    n_last++;
                    last_idx = seen.size() - 1;
                end
                if (exp_q.size() == 0) begin
                    m_active = 0;
                    m_fc++;
                end
            end else if (was) begin
                held   = 1;
                h_data = data;
                h_last = data_last;
            end
            m_drop = 0;
            if (frame_start) begin
                if (!was && chipcount != 0) begin
                    for (int c = 0; c < int'(chipcount); c++)
                        for (int k = 0; k < CH; k++)
                            exp_q.push_back(pix(mode, brightness, c, k, m_fc));
                    m_active = 1;
                end else begin
                    m_drop = 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        data_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic start(input logic [15:0] cc, input logic [1:0] m, input logic [15:0] b);
        @(posedge clk);
        #1;
        chipcount   = cc;
        mode        = m;
        brightness  = b;
        frame_start = 1;
        @(posedge clk);
        #1;
        frame_start = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (busy || data_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3 rst = 0;
        #4;
        chk("rst_data", data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_last", data_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // solid frame, two chips, full throughput
        seen.delete();
        n_last = 0;
        start(2, 0, 16'h1234);
        chk("t1_first_valid", data_valid, 1);
        chk("t1_first_data", data, 16'h1234);
        wait_idle();
        chk("t1_words", seen.size(), 32);
        chk("t1_nlast", n_last, 1);
        chk("t1_last_idx", last_idx, 31);
        chk("t1_frame_cnt", frame_cnt, 1);

        // ramp frames; second one has f=2
        for (int fr = 0; fr < 3; fr++) begin
            seen.delete();
            start(1, 1, 16'h0000);
            wait_idle();
            chk("t2_words", seen.size(), 16);
            if (fr == 1) begin
                chk("t2_f2_w0", seen[0], 16'h0200);
                chk("t2_f2_w15", seen[15], 16'h1100);
            end
        end

        // chase under random backpressure
        bp = 1;
        for (int fr = 0; fr < 2; fr++) begin
            seen.delete();
            start(3, 2, 16'hFFFF);
            wait_idle();
            chk("t3_words", seen.size(), 48);
            nf = 0;
            foreach (seen[i]) if (seen[i] == 16'hFFFF) nf++;
            chk("t3_lit_count", nf, 3);
        end
        bp = 0;
        repeat (2) @(posedge clk);
        #1;

        // frame_start mid-frame and coincident with the last handshake
        seen.delete();
        d0 = n_drop;
        f0 = frame_cnt;
        start(1, 0, 16'h00AA);
        repeat (5) @(posedge clk);
        #1 frame_start = 1;
        @(posedge clk);
        #1 frame_start = 0;
        for (int i = 0; i < 100 && !data_last; i++) begin
            @(posedge clk);
            #1;
        end
        frame_start = 1;
        @(posedge clk);
        #1 frame_start = 0;
        wait_idle();
        chk("t4_words", seen.size(), 16);
        chk("t4_drops", n_drop - d0, 2);
        chk("t4_frame_cnt", frame_cnt, f0 + 16'd1);
        chk("t4_idle_valid", data_valid, 0);

        // chipcount zero is dropped
        seen.delete();
        d0 = n_drop;
        f0 = frame_cnt;
        start(0, 0, 16'h5555);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_words", seen.size(), 0);
        chk("t5_drops", n_drop - d0, 1);
        chk("t5_frame_cnt", frame_cnt, f0);

        // asynchronous reset in the middle of a frame
        seen.delete();
        start(2, 1, 16'h0000);
        for (int i = 0; i < 100 && seen.size() < 10; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_busy_before", busy, 1);
        #1 rst = 0;
        #1;
        chk("t6_rst_data", data, 0);
        chk("t6_rst_valid", data_valid, 0);
        chk("t6_rst_last", data_last, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1 rst = 1;
        seen.delete();
        n_last = 0;
        start(1, 1, 16'h0000);
        wait_idle();
        chk("t6_words", seen.size(), 16);
        chk("t6_w0", seen[0], 16'h0000);
        chk("t6_w15", seen[15], 16'h0F00);
        chk("t6_nlast", n_last, 1);
        chk("t6_frame_cnt", frame_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
